branch_resolve_unit: RTL and testbench

Parametrised, pipelined branch/jump resolution stage for the RISC-V core, placed between operand fetch and PC update. Takes one control-flow op per cycle over a valid/ready handshake and evaluates the RV32I branch conditions, JAL and JALR. The result is registered, together with a misprediction flag and the correct next PC for the fetch redirect. It replaces the unclocked, enable-edge branch evaluator and adds backpressure, flush, mispredict detection and optional performance counters.

---
 rtl/branch_resolve_unit.sv | 161 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Pipelined RV32I branch/JAL/JALR resolution stage with registered result and mispredict flag.
// Optional performance counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 10,
  parameter int unsigned IMMW   = 20,
  parameter int unsigned PC_INC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_b,
  input  logic            in_j,
  input  logic            in_jalr,
  input  logic [2:0]      in_funct3,
  input  logic [IMMW-1:0] in_imm,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [AW-1:0]   in_pc,
  input  logic            in_pred_taken,
  input  logic [AW-1:0]   in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [AW-1:0]   out_target,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic [31:0]     cnt_branch,
  output logic [31:0]     cnt_taken,
  output logic [31:0]     cnt_mispred
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic            accept;
  logic            cond_c;
  logic            reserved_c;
  logic            taken_c;
  logic            illegal_c;
  logic            mispredict_c;
  logic [AW-1:0]   rel_target_c;
  logic [AW-1:0]   jalr_target_c;
  logic [AW-1:0]   seq_pc_c;
  logic [AW-1:0]   target_c;

  assign out_valid = (state == FULL);
  assign in_ready  = (state == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready & ~flush;

  // All address arithmetic wraps modulo 2^AW; IMMW >= AW so truncating the sum is the sign-extended add.
  assign rel_target_c = AW'(IMMW'(in_pc) + in_imm);
  assign seq_pc_c     = in_pc + AW'(PC_INC);

  always_comb begin
    jalr_target_c    = AW'(in_op1) + AW'(in_imm);
    jalr_target_c[0] = 1'b0;
  end

  // Branch condition decode
  always_comb begin
    cond_c     = 1'b0;
    reserved_c = 1'b0;
    case (in_funct3)
      3'b000:  cond_c = (in_op1 == in_op2);
      3'b001:  cond_c = (in_op1 != in_op2);
      3'b100:  cond_c = ($signed(in_op1) <  $signed(in_op2));
      3'b101:  cond_c = ($signed(in_op1) >= $signed(in_op2));
      3'b110:  cond_c = (in_op1 <  in_op2);
      3'b111:  cond_c = (in_op1 >= in_op2);
      default: reserved_c = 1'b1;
    endcase
  end

  // Resolved direction, next PC and mispredict against the front-end guess
  always_comb begin
    taken_c   = in_j | in_jalr | (in_b & cond_c);
    illegal_c = in_b & reserved_c;
    target_c  = seq_pc_c;
    if (in_jalr) begin
      target_c = jalr_target_c;
    end else if (taken_c) begin
      target_c = rel_target_c;
    end
    mispredict_c = (in_pred_taken != taken_c) |
                   (in_pred_taken & taken_c & (in_pred_target != target_c));
  end

  // Output register FSM; flush wins over accept and drops the held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= EMPTY;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (flush) begin
            state <= EMPTY;
          end else if (out_ready && !accept) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (flush) begin
        state <= EMPTY;
      end
      if (accept) begin
        out_taken      <= taken_c;
        out_target     <= target_c;
        out_mispredict <= mispredict_c;
        out_illegal    <= illegal_c;
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic held_ctrl;
  logic retire;

  assign retire = out_valid & out_ready & ~flush & held_ctrl;

  // Counters sample only completed, non-flushed control-flow results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_ctrl   <= 1'b0;
      cnt_branch  <= '0;
      cnt_taken   <= '0;
      cnt_mispred <= '0;
    end else begin
      if (accept) begin
        held_ctrl <= in_b | in_j | in_jalr;
      end
      if (retire) begin
        cnt_branch <= cnt_branch + 32'd1;
        if (out_taken) begin
          cnt_taken <= cnt_taken + 32'd1;
        end
        if (out_mispredict) begin
          cnt_mispred <= cnt_mispred + 32'd1;
        end
      end
    end
  end
`else
  assign cnt_branch  = '0;
  assign cnt_taken   = '0;
  assign cnt_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + random bench for branch_resolve_unit with a result scoreboard and counter model.
module tb_branch_resolve_unit;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned AW     = 10;
  localparam int unsigned IMMW   = 20;
  localparam int unsigned PC_INC = 4;
  localparam int          AMASK  = (1 << AW) - 1;

  typedef struct packed {
    logic          ctrl;
    logic          taken;
    logic [AW-1:0] target;
    logic          mis;
    logic          ill;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_b, in_j, in_jalr;
  logic [2:0]      in_funct3;
  logic [IMMW-1:0] in_imm;
  logic [XLEN-1:0] in_op1, in_op2;
  logic [AW-1:0]   in_pc;
  logic            in_pred_taken;
  logic [AW-1:0]   in_pred_target;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [AW-1:0]   out_target;
  logic            out_mispredict;
  logic            out_illegal;
  logic [31:0]     cnt_branch, cnt_taken, cnt_mispred;

  branch_resolve_unit #(.XLEN(XLEN), .AW(AW), .IMMW(IMMW), .PC_INC(PC_INC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_b(in_b), .in_j(in_j), .in_jalr(in_jalr), .in_funct3(in_funct3),
    .in_imm(in_imm), .in_op1(in_op1), .in_op2(in_op2), .in_pc(in_pc),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_mispredict(out_mispredict), .out_illegal(out_illegal),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken), .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   exp_br = 0, exp_tk = 0, exp_mp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic b, input logic j, input logic jr,
                                 input logic [2:0] f3, input logic [IMMW-1:0] imm,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] c,
                                 input logic [AW-1:0] pc, input logic pt,
                                 input logic [AW-1:0] ptg);
    exp_t e;
    int sx, rel, seq, jt;
    sx  = int'($signed(imm));
    rel = (int'(pc) + sx) & AMASK;
    seq = (int'(pc) + int'(PC_INC)) & AMASK;
    jt  = ((int'(a) & AMASK) + sx) & AMASK & ~1;
    e.ctrl  = b | j | jr;
    e.ill   = 1'b0;
    e.taken = 1'b0;
    if (j || jr) e.taken = 1'b1;
    else if (b) begin
      case (f3)
        3'd0: e.taken = (a == c);
        3'd1: e.taken = (a != c);
        3'd4: e.taken = ($signed(a) <  $signed(c));
        3'd5: e.taken = ($signed(a) >= $signed(c));
        3'd6: e.taken = (a <  c);
        3'd7: e.taken = (a >= c);
        default: e.ill = 1'b1;
      endcase
    end
    e.target = AW'(e.taken ? (jr ? jt : rel) : seq);
    e.mis    = (pt != e.taken) || (pt && e.taken && (ptg != e.target));
    return e;
  endfunction

  // Scoreboard: compare held result every cycle, retire on handshake, push on accept
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 32'(out_valid), 32'd0);
          end else begin
            check("sb_taken",  32'(out_taken),      32'(sb[0].taken));
            check("sb_target", 32'(out_target),     32'(sb[0].target));
            check("sb_mis",    32'(out_mispredict), 32'(sb[0].mis));
            check("sb_ill",    32'(out_illegal),    32'(sb[0].ill));
            if (out_ready) begin
`ifdef BRANCH_PERF_CNT_EN
              if (sb[0].ctrl) begin
                exp_br++;
                if (sb[0].taken) exp_tk++;
                if (sb[0].mis)   exp_mp++;
              end
`endif
              void'(sb.pop_front());
            end
          end
        end
        if (in_valid && in_ready) begin
          sb.push_back(model(in_b, in_j, in_jalr, in_funct3, in_imm, in_op1, in_op2,
                             in_pc, in_pred_taken, in_pred_target));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                         input logic [IMMW-1:0] imm, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] c, input logic [AW-1:0] pc,
                         input logic pt, input logic [AW-1:0] ptg);
    in_valid = 1'b1; in_b = b; in_j = j; in_jalr = jr; in_funct3 = f3; in_imm = imm;
    in_op1 = a; in_op2 = c; in_pc = pc; in_pred_taken = pt; in_pred_target = ptg;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_b = 1'b0; in_j = 1'b0; in_jalr = 1'b0;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_cnt_branch"},  cnt_branch,  32'(exp_br));
    check({tag, "_cnt_taken"},   cnt_taken,   32'(exp_tk));
    check({tag, "_cnt_mispred"}, cnt_mispred, 32'(exp_mp));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_imm = '0; in_op1 = '0; in_op2 = '0; in_pc = '0;
    in_pred_taken = 1'b0; in_pred_target = '0;
    idle();
    #12;
    check("rst_valid",  32'(out_valid),      32'd0);
    check("rst_taken",  32'(out_taken),      32'd0);
    check("rst_target", 32'(out_target),     32'd0);
    check("rst_mis",    32'(out_mispredict), 32'd0);
    check("rst_ill",    32'(out_illegal),    32'd0);
    check_cnts("rst");
    @(negedge clk) rst = 1'b0;
    step();
    check("idle_in_ready", 32'(in_ready),  32'd1);
    check("idle_valid",    32'(out_valid), 32'd0);

    set_req(1, 0, 0, 3'b100, 20'h00020, 32'hFFFFFFFF, 32'd1, 10'h010, 1'b0, 10'h000);
    step();
    check("blt_valid",  32'(out_valid),      32'd1);
    check("blt_taken",  32'(out_taken),      32'd1);
    check("blt_target", 32'(out_target),     32'h030);
    check("blt_mis",    32'(out_mispredict), 32'd1);
    in_funct3 = 3'b110;
    step();
    check("bltu_taken",  32'(out_taken),      32'd0);
    check("bltu_target", 32'(out_target),     32'h014);
    check("bltu_mis",    32'(out_mispredict), 32'd0);

    set_req(0, 0, 1, 3'b000, 20'h0000A, 32'h105, 32'd0, 10'h040, 1'b1, 10'h10E);
    step();
    check("jalr_target", 32'(out_target),     32'h10E);
    check("jalr_taken",  32'(out_taken),      32'd1);
    check("jalr_mis0",   32'(out_mispredict), 32'd0);
    in_pred_target = 10'h110;
    step();
    check("jalr_mis1",   32'(out_mispredict), 32'd1);

    set_req(1, 0, 0, 3'b010, 20'h00010, 32'd5, 32'd5, 10'h080, 1'b0, 10'h000);
    step();
    check("rsv_ill",    32'(out_illegal),    32'd1);
    check("rsv_taken",  32'(out_taken),      32'd0);
    check("rsv_target", 32'(out_target),     32'h084);

    set_req(1, 0, 0, 3'b000, 20'h00008, 32'd7, 32'd7, 10'h3FC, 1'b1, 10'h004);
    step();
    check("wrap_up_target", 32'(out_target),     32'h004);
    check("wrap_up_mis",    32'(out_mispredict), 32'd0);
    set_req(0, 1, 0, 3'b000, 20'hFFFF8, 32'd0, 32'd0, 10'h004, 1'b0, 10'h000);
    step();
    check("wrap_dn_target", 32'(out_target), 32'h3FC);
    idle();
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: A held two cycles while B waits, then B and C stream through
    out_ready = 1'b0;
    set_req(1, 0, 0, 3'b001, 20'h00010, 32'd1, 32'd2, 10'h100, 1'b1, 10'h110);
    step();
    set_req(1, 0, 0, 3'b101, 20'h00010, 32'hFFFFFFFF, 32'd1, 10'h120, 1'b0, 10'h000);
    for (int i = 0; i < 2; i++) begin
      check("bp_in_ready", 32'(in_ready),   32'd0);
      check("bp_hold_tgt", 32'(out_target), 32'h110);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_b_target", 32'(out_target), 32'h124);
    set_req(0, 1, 0, 3'b000, 20'h00040, 32'd0, 32'd0, 10'h200, 1'b1, 10'h240);
    step();
    check("bp_c_target", 32'(out_target), 32'h240);
    idle();
    step();
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with a same-cycle accept while FULL
    out_ready = 1'b0;
    set_req(0, 1, 0, 3'b000, 20'h00004, 32'd0, 32'd0, 10'h300, 1'b0, 10'h000);
    step();
    out_ready = 1'b1; flush = 1'b1;
    set_req(1, 0, 0, 3'b000, 20'h00004, 32'd1, 32'd1, 10'h310, 1'b0, 10'h000);
    step();
    flush = 1'b0;
    idle();
    check("flush_valid", 32'(out_valid), 32'd0);
    check_cnts("flush");
    step();
    check("flush_valid2", 32'(out_valid), 32'd0);

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    set_req(0, 1, 0, 3'b000, 20'h00008, 32'd0, 32'd0, 10'h050, 1'b0, 10'h000);
    step();
    idle();
    check("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  32'(out_valid),  32'd0);
    check("mid_rst_target", 32'(out_target), 32'd0);
    sb.delete();
    exp_br = 0; exp_tk = 0; exp_mp = 0;
    check_cnts("mid_rst");
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      set_req(kind == 0, kind == 1, kind == 2, 3'($urandom), 20'($urandom),
              32'($urandom_range(0, 3)) - 32'd1, 32'($urandom_range(0, 3)) - 32'd1,
              10'($urandom), 1'($urandom), 10'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    out_ready = 1'b1;
    step();
    step();
    check("final_valid", 32'(out_valid), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check_cnts("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
